imem_loader: RTL and testbench

Write-side companion to the instruction ROM. Accepts a framed byte stream from the UART receiver, assembles little-endian 32-bit words and writes them sequentially into the word-addressed instruction RAM that replaces the file-initialised ROM. Holds the core in reset while a load is in progress, then reports success or error.

---
 rtl/imem_loader_pkg.sv | 15 +
 rtl/imem_loader.sv | 152 +++++++++++++++
 tb/tb_imem_loader.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and frame geometry.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CHECK
    } state_t;

    localparam int HEADER_BYTES   = 2;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_loader.sv
// Receives a length-prefixed, checksummed byte stream and writes it word by word
// into the instruction RAM, holding the core in reset for the duration of the load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  busy,
    output logic                  hold_cpu,
    output logic                  done,
    output logic                  error
);

    localparam int TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LW   = $clog2(BYTES_PER_WORD);
    localparam int IW   = ADDR_WIDTH + 1;
    localparam int LENW = 8 * HEADER_BYTES;
    localparam logic [LW-1:0]   LAST_LANE = LW'(BYTES_PER_WORD - 1);
    localparam logic [LENW-1:0] MAX_WORDS = LENW'(2 ** ADDR_WIDTH);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

    state_t                           state, state_next;
    logic [TW-1:0]                    tmo_cnt;
    logic [LW-1:0]                    lane;
    logic [IW-1:0]                    widx;
    logic [7:0]                       csum;
    logic [LENW-1:0]                  len;
    logic [8*(BYTES_PER_WORD-1)-1:0]  asm_q;

    logic [LENW-1:0] n_hdr;
    logic            len_ok;
    logic            timeout;
    logic            word_end;
    logic            last_word;
    logic            we_next;
    logic            done_next;
    logic            err_set;

    // The top length byte completes N; an empty or oversized image is refused up front.
    assign n_hdr     = {rx_data, len[7:0]};
    assign len_ok    = (n_hdr != '0) && (n_hdr <= MAX_WORDS);
    // A byte arriving on the final idle cycle rescues the frame.
    assign timeout   = (state != IDLE) && !rx_valid && (tmo_cnt == TMO_LAST);
    assign word_end  = (state == DATA) && rx_valid && (lane == LAST_LANE);
    assign last_word = word_end && (LENW'(widx) + LENW'(1) == len);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            // NOTE: every flop is updated with <= so all registers see pre-edge values.
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first, so no path through the case leaves state_next unassigned (no latch).
        state_next = state;
        if (timeout) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start)     state_next = LEN_LO;
                LEN_LO:  if (rx_valid)  state_next = LEN_HI;
                LEN_HI:  if (rx_valid)  state_next = len_ok ? DATA : IDLE;
                DATA:    if (last_word) state_next = CHECK;
                CHECK:   if (rx_valid)  state_next = IDLE;
                default:                state_next = IDLE;
            endcase
        end
    end

    always_comb begin
        we_next   = word_end;
        done_next = (state == CHECK) && rx_valid && (rx_data == csum);
        err_set   = timeout
                  || ((state == LEN_HI) && rx_valid && !len_ok)
                  || ((state == CHECK)  && rx_valid && (rx_data != csum));
    end

    // NOTE: only loader state is reset here; the instruction RAM itself is never cleared.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            busy      <= 1'b0;
            hold_cpu  <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            tmo_cnt   <= '0;
            lane      <= '0;
            widx      <= '0;
            csum      <= '0;
            len       <= '0;
            asm_q     <= '0;
        end else begin
            mem_we   <= we_next;
            done     <= done_next;
            busy     <= (state_next != IDLE);
            hold_cpu <= (state_next != IDLE);

            if (state == IDLE && start) begin
                error <= 1'b0;
            end else if (err_set) begin
                error <= 1'b1;
            end

            if (state_next != state || rx_valid) begin
                tmo_cnt <= '0;
            end else if (state != IDLE) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end

            // A new session discards any partial word left behind by an aborted frame.
            if (state == IDLE && start) begin
                csum <= '0;
                lane <= '0;
                widx <= '0;
            end

            if (state == LEN_LO && rx_valid) begin
                len[7:0] <= rx_data;
            end
            if (state == LEN_HI && rx_valid) begin
                len <= n_hdr;
            end

            if (state == DATA && rx_valid) begin
                csum <= csum + rx_data;
                lane <= lane + 1'b1;
                if (lane != LAST_LANE) begin
                    asm_q[8*lane +: 8] <= rx_data;
                end else begin
                    mem_wdata <= {rx_data, asm_q};
                    mem_addr  <= widx[ADDR_WIDTH-1:0];
                    widx      <= widx + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomised self-checking bench for imem_loader; expected writes and outcomes come
// from the frame rules applied directly to the generated image.
module tb_imem_loader;

    localparam int AW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          rx_valid = 1'b0;
    logic [7:0]    rx_data = '0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic          busy;
    logic          hold_cpu;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;

    logic [31:0]   words [256];
    logic [AW-1:0] got_addr [$];
    logic [31:0]   got_data [$];

    imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .busy     (busy),
        .hold_cpu (hold_cpu),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            got_addr.push_back(mem_addr);
            got_data.push_back(mem_wdata);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit with_start);
        rx_valid = 1'b1;
        rx_data  = b;
        start    = with_start;
        tick();
        rx_valid = 1'b0;
        start    = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || hold_cpu !== 1'b1 || error !== 1'b0) begin
            errors++;
            $display("FAIL start_accept: busy=%b hold_cpu=%b error=%b, required 1 1 0", busy, hold_cpu, error);
        end
    endtask

    task automatic expect_idle_outputs(input string name, input logic exp_err);
        checks++;
        if (busy !== 1'b0 || hold_cpu !== 1'b0 || error !== exp_err) begin
            errors++;
            $display("FAIL %s: busy=%b hold_cpu=%b error=%b, required 0 0 %b", name, busy, hold_cpu, error, exp_err);
        end
    endtask

    // Sends a complete frame for words[0..n-1] and checks writes, done and error.
    task automatic run_frame(input string name, input int n, input bit corrupt, input int gap_max);
        logic [7:0]  cs;
        logic [7:0]  b;
        logic [15:0] n16;
        n16 = 16'(n);
        cs  = 8'h00;
        send_byte(8'($urandom), 0, 1'b0);  // stray byte in IDLE, must be ignored
        got_addr.delete();
        got_data.delete();
        do_start();
        send_byte(n16[7:0],  $urandom_range(gap_max, 0), 1'b0);
        send_byte(n16[15:8], $urandom_range(gap_max, 0), 1'b0);
        for (int w = 0; w < n; w++) begin
            for (int k = 0; k < 4; k++) begin
                b  = words[w][8*k +: 8];
                cs = cs + b;
                send_byte(b, $urandom_range(gap_max, 0), ($urandom_range(15, 0) == 0));
            end
        end
        rx_valid = 1'b1;
        rx_data  = corrupt ? cs + 8'($urandom_range(255, 1)) : cs;
        tick();
        rx_valid = 1'b0;
        checks++;
        if (done !== !corrupt || busy !== 1'b0 || error !== corrupt) begin
            errors++;
            $display("FAIL %s_end: done=%b busy=%b error=%b, required %b 0 %b",
                     name, done, busy, error, !corrupt, corrupt);
        end
        repeat (3) tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%b three cycles later, required 0", name, done);
        end
        checks++;
        if (got_addr.size() != n) begin
            errors++;
            $display("FAIL %s_write_count: got %0d writes, required %0d", name, got_addr.size(), n);
        end else begin
            for (int w = 0; w < n; w++) begin
                checks++;
                if (got_addr[w] !== AW'(w) || got_data[w] !== words[w]) begin
                    errors++;
                    $display("FAIL %s_write%0d: addr=%0d data=%h, required addr=%0d data=%h",
                             name, w, got_addr[w], got_data[w], w, words[w]);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, busy, hold_cpu, done, error} !== '0) begin
            errors++;
            $display("FAIL reset_values: we=%b addr=%h wdata=%h busy=%b hold=%b done=%b error=%b, required all 0",
                     mem_we, mem_addr, mem_wdata, busy, hold_cpu, done, error);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single_word();
        words[0] = 32'h12345678;
        run_frame("single", 1, 1'b0, 0);
    endtask

    task automatic test_full_image();
        for (int i = 0; i < 256; i++) words[i] = 32'(i);
        run_frame("full", 256, 1'b0, 2);
        repeat (10) tick();
        checks++;
        if (got_addr.size() != 256) begin
            errors++;
            $display("FAIL full_no_wrap: %0d writes after done, required 256", got_addr.size());
        end
    endtask

    task automatic test_bad_length();
        logic [7:0] hdr [4];
        hdr = '{8'h00, 8'h00, 8'h01, 8'h01};
        for (int t = 0; t < 2; t++) begin
            got_addr.delete();
            do_start();
            send_byte(hdr[2*t], 0, 1'b0);
            send_byte(hdr[2*t+1], 0, 1'b0);
            expect_idle_outputs(t == 0 ? "bad_len_zero" : "bad_len_257", 1'b1);
            repeat (4 * TMO) tick();
            checks++;
            if (got_addr.size() != 0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL bad_len_nowrite%0d: writes=%0d busy=%b, required 0 0", t, got_addr.size(), busy);
            end
        end
    endtask

    task automatic test_bad_checksum();
        words[0] = $urandom;
        words[1] = $urandom;
        run_frame("bad_csum", 2, 1'b1, 1);
        words[0] = $urandom;
        run_frame("after_bad_csum", 1, 1'b0, 1);
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 6; f++) begin
            int  n;
            bit  bad;
            n   = $urandom_range(8, 1);
            bad = ($urandom_range(2, 0) == 0);
            for (int i = 0; i < n; i++) words[i] = $urandom;
            run_frame($sformatf("rand%0d", f), n, bad, TMO - 2);
        end
    endtask

    task automatic test_timeout();
        got_addr.delete();
        do_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hAA, 0, 1'b0);
        send_byte(8'hBB, 0, 1'b0);
        for (int c = 1; c <= TMO; c++) begin
            if (c == TMO - 1) begin
                checks++;
                if (error !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_early: cycle %0d error=%b busy=%b, required 0 1", c, error, busy);
                end
            end
            tick();
        end
        expect_idle_outputs("timeout_fire", 1'b1);
        checks++;
        if (got_addr.size() != 0) begin
            errors++;
            $display("FAIL timeout_nowrite: %0d writes, required 0", got_addr.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        do_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'h11, 0, 1'b0);
        send_byte(8'h22, 0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_we, mem_addr, mem_wdata, busy, hold_cpu, done, error} !== '0) begin
            errors++;
            $display("FAIL reset_mid: we=%b addr=%h wdata=%h busy=%b hold=%b done=%b error=%b, required all 0",
                     mem_we, mem_addr, mem_wdata, busy, hold_cpu, done, error);
        end
        tick();
        reset = 1'b0;
        tick();
        words[0] = 32'hCAFE_F00D;
        run_frame("after_reset", 1, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_image();
        test_bad_length();
        test_bad_checksum();
        test_random_frames();
        test_timeout();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
